// File: rtl/piso_serializer.sv
// piso_serializer: 4-bit parallel-in, serial-out shifter, LSB first.
//
// Ports:
//   clk   - rising-edge clock for all state
//   rst   - asynchronous, active-high reset
//   start - capture d and begin a word (honoured only while ready)
//   d     - parallel word, d[0] is emitted first
//   ready - high in IDLE, when start will be accepted
//   busy  - high while bits are being emitted
//   sout  - serial data out, taken from registered state only
//   done  - one-cycle pulse after the last emitted bit
//
// Optional feature: define PISO_PARITY_EN to append one even-parity bit
// (XOR of the captured word) after d[3].

module piso_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] d,
    output logic       ready,
    output logic       busy,
    output logic       sout,
    output logic       done
);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

    state_e     state_q, state_d;
    logic [3:0] sreg_q, sreg_d;
    logic [1:0] cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
    logic       parity_q, parity_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            sreg_q   <= 4'b0000;
            cnt_q    <= 2'd0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Outputs decode the registered state only, so they settle right after
    // an edge (or immediately on reset) and never follow start/d directly.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        ready    = 1'b0;
        busy     = 1'b0;
        sout     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    sreg_d   = d;
                    cnt_d    = 2'd0;
`ifdef PISO_PARITY_EN
                    parity_d = ^d;
`endif
                    state_d  = StShift;
                end
            end
            StShift: begin
                busy   = 1'b1;
                sout   = sreg_q[0];
                sreg_d = {1'b0, sreg_q[3:1]};
                // Counter wraps 3 -> 0 on the same edge that leaves SHIFT.
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
`ifdef PISO_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            StParity: begin
                busy    = 1'b1;
                sout    = parity_q;
                state_d = StDone;
            end
`endif
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request to capture d and begin transmission.
REQ-004 SHALL have port: d  input  4  parallel word from the upstream 4-bit register (d[0] = q0 ... d[3] = q3).
REQ-005 SHALL have port: ready  output  1  high when start will be accepted.
REQ-006 SHALL have port: busy  output  1  high while bits are being emitted.
REQ-007 SHALL have port: sout  output  1  serial data out, LSB first.
REQ-008 SHALL have port: done  output  1  one-cycle pulse after the last emitted bit.
REQ-009 SHALL use one clock, clk; reset is rst, asynchronous and active-high.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, PARITY and DONE; PARITY SHALL exist only under PARITY_EN.
REQ-011 SHALL hold ready=1 only in IDLE; busy=1 in SHIFT and PARITY; done=1 only in DONE.
REQ-012 SHALL, at a rising edge in IDLE with start=1:
- copy d into a 4-bit shift register;
- clear the 2-bit bit counter;
- move to SHIFT.
REQ-013 SHALL drive sout from the registered shift-register LSB in SHIFT, so sout changes only on clock edges.
REQ-014 SHALL, in SHIFT, shift the register right by one bit and increment the counter at each edge.
- After the edge where counter==3, go to PARITY if PARITY_EN is defined, else to DONE.
REQ-015 SHALL emit d[0], d[1], d[2], d[3] in the 1st to 4th cycles after the accepting edge.
REQ-016 SHALL stay in DONE for exactly one cycle, then return to IDLE.
REQ-017 SHALL drive sout=0 in IDLE and DONE.
REQ-018 SHALL ignore start in SHIFT, PARITY and DONE; no queuing, no restart.
REQ-019 SHALL make changes on d after the accepting edge have no effect on the word in flight.
REQ-020 SHALL accept start held high continuously on every IDLE cycle.
- Back-to-back words are spaced 6 cycles apart (7 with PARITY_EN).
REQ-021 SHALL wrap the bit counter from 3 to 0 only on leaving SHIFT; it is never read outside SHIFT.

Reset
REQ-022 SHALL, while rst=1, immediately force:
- state IDLE, shift register 0, counter 0;
- ready=1, busy=0, sout=0, done=0.
REQ-023 SHALL abort a transmission when rst is asserted mid-word; no done pulse is produced for the aborted word.
REQ-024 SHALL accept start at the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL compile the parity feature only when macro PISO_PARITY_EN is defined.
REQ-026 SHALL, with PISO_PARITY_EN defined:
- latch even parity (XOR of d[3:0]) at the accepting edge;
- emit it on sout for one cycle in the PARITY state, between d[3] and DONE.
REQ-027 SHALL, without PISO_PARITY_EN, contain no parity logic, and SHIFT goes directly to DONE.

Verification
REQ-028 SHALL cover: rst=1 mid-bench -> immediately ready=1, busy=0, sout=0, done=0.
REQ-029 SHALL cover: d=4'b1010, single start pulse -> sout 0,1,0,1 over 4 cycles, then done=1 for one cycle (no parity).
REQ-030 SHALL cover: PISO_PARITY_EN defined, d=4'b1011 -> sout 1,1,0,1, then parity 1, then done pulse.
REQ-031 SHALL cover: d changed 4'b1100->4'b0011 and start re-pulsed during SHIFT -> output still 0,0,1,1; no second word.
REQ-032 SHALL cover: start held high, d=4'b0011 then 4'b1100 -> two words, done pulses 6 cycles apart (7 with parity).
REQ-033 SHALL cover: rst pulsed after the 2nd bit of d=4'b1111 -> sout=0 at once, no done pulse, next start serializes normally.
